mac_bfusion1d_seq: RTL and testbench

//  Operand sequencer and result capture for the 1D 1-level BitFusion MAC (top_mac_bfusion1d).
//  - Feeds the MAC from a valid/ready operand stream and drives its a/w/mode/accu_rst inputs.
//  - Splits the stream into dot-product windows marked by s_last.
//  - Captures the finished accumulator from z and pushes it into a small result FIFO with a valid/ready output.

---
 rtl/mac_bfusion1d_pkg.sv | 19 +
 rtl/mac_bfusion1d_res_fifo.sv | 68 ++++++
 rtl/mac_bfusion1d_seq.sv | 124 ++++++++++++
 tb/tb_mac_bfusion1d_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_bfusion1d_pkg.sv
// Shared definitions for the BitFusion 1D MAC sequencer slice.
package mac_bfusion1d_pkg;

  // Cycles from operand accept to the result being visible on mac_z
  // (input reg, mult reg, z reg).
  localparam int PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    GAP
  } seq_state_t;

  // Accumulator width for a given headroom.
  function automatic int zw(input int headroom);
    return 16 + headroom;
  endfunction

endpackage

// File: rtl/mac_bfusion1d_res_fifo.sv
// Small result FIFO with count output; push and pop may coincide when full.
module mac_bfusion1d_res_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy next-state; a push into a full FIFO is only taken
  // when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign valid    = (count_q != '0);
  assign count    = count_q;

endmodule

// File: rtl/mac_bfusion1d_seq.sv
// Operand sequencer and result capture for the 1D 1-level BitFusion MAC.
module mac_bfusion1d_seq
  import mac_bfusion1d_pkg::*;
#(
  parameter int HEADROOM  = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_mode,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [15:0]               s_a,
  input  logic [7:0]                s_w,
  input  logic                      s_last,
  output logic [15:0]               mac_a,
  output logic [7:0]                mac_w,
  output logic                      mac_mode,
  output logic                      mac_accu_rst,
  input  logic [zw(HEADROOM)-1:0]   mac_z,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [zw(HEADROOM)-1:0]   m_data,
  output logic                      busy
);

  localparam int ZW = zw(HEADROOM);
  localparam int LW = 13 + HEADROOM;  // live accumulator bits in 2x 8x4b mode
  localparam int CW = $clog2(RES_DEPTH + 1);

  seq_state_t           state_q, state_d;
  logic [PIPE_LAT-1:0]  lastp_q, lastp_d;
  logic [CW-1:0]        pending_q, pending_d;
  logic                 mode_q, mode_d;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_valid;
  logic                 rdy_int;
  logic                 accept;
  logic                 first_beat;
  logic                 capture;
  logic                 credit_ok;
  logic                 mode_block;
  logic [ZW-1:0]        result;

  // Handshake, sequencing and credit next-state.
  always_comb begin
    credit_ok  = (int'(fifo_count) + int'(pending_q)) < RES_DEPTH;
    // A mode switch must wait until the previous window's capture, because
    // the MAC applies mode to in-flight products without registering it.
    mode_block = (cfg_mode != mode_q) && (lastp_q != '0);
    rdy_int    = 1'b0;
    case (state_q)
      IDLE:    rdy_int = credit_ok && !mode_block;
      ACC:     rdy_int = 1'b1;
      GAP:     rdy_int = 1'b0;
      default: rdy_int = 1'b0;
    endcase
    s_ready    = rst_n && rdy_int;
    accept     = s_valid && s_ready;
    first_beat = accept && (state_q == IDLE);
    capture    = lastp_q[PIPE_LAT-1];

    state_d = state_q;
    case (state_q)
      IDLE:    if (first_beat) state_d = s_last ? GAP : ACC;
      ACC:     if (accept && s_last) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    lastp_d = {lastp_q[PIPE_LAT-2:0], accept && s_last};

    pending_d = pending_q;
    if (first_beat && !capture) begin
      pending_d = pending_q + 1'b1;
    end else if (capture && !first_beat) begin
      pending_d = pending_q - 1'b1;
    end

    mode_d = first_beat ? cfg_mode : mode_q;

    // Upper accumulator bits are not maintained by the MAC in split mode.
    result = mode_q ? {{(ZW - LW){mac_z[LW-1]}}, mac_z[LW-1:0]} : mac_z;
  end

  // Sequencer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lastp_q   <= '0;
      pending_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lastp_q   <= lastp_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
    end
  end

  mac_bfusion1d_res_fifo #(
    .WIDTH (ZW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (result),
    .pop       (m_ready),
    .pop_data  (m_data),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  // Stalls feed zeros so they add nothing to the accumulator.
  assign mac_a        = accept ? s_a : '0;
  assign mac_w        = accept ? s_w : '0;
  assign mac_accu_rst = first_beat;
  assign mac_mode     = rst_n && mode_q;
  assign m_valid      = rst_n && fifo_valid;
  assign busy         = rst_n && ((state_q != IDLE) || (pending_q != '0) || (fifo_count != '0));

endmodule

// File: tb/tb_mac_bfusion1d_seq.sv
// Self-checking bench for mac_bfusion1d_seq with a behavioural MAC model.
module tb_mac_bfusion1d_seq;

  localparam int HEADROOM  = 4;
  localparam int RES_DEPTH = 2;
  localparam int ZW        = 16 + HEADROOM;
  localparam int LW        = 13 + HEADROOM;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_mode = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [15:0]     s_a = '0;
  logic [7:0]      s_w = '0;
  logic            s_last = 1'b0;
  logic [15:0]     mac_a;
  logic [7:0]      mac_w;
  logic            mac_mode;
  logic            mac_accu_rst;
  logic [ZW-1:0]   mac_z;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [ZW-1:0]   m_data;
  logic            busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_bfusion1d_seq #(
    .HEADROOM  (HEADROOM),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_mode     (cfg_mode),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_a          (s_a),
    .s_w          (s_w),
    .s_last       (s_last),
    .mac_a        (mac_a),
    .mac_w        (mac_w),
    .mac_mode     (mac_mode),
    .mac_accu_rst (mac_accu_rst),
    .mac_z        (mac_z),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy)
  );

  // Dot-product contribution of one beat: unsigned activations times signed weights.
  function automatic int dot(input logic [15:0] a, input logic [7:0] w, input logic mode);
    int lo_a;
    int hi_a;
    lo_a = int'(a[7:0]);
    hi_a = int'(a[15:8]);
    if (!mode) return lo_a * int'($signed(w));
    return lo_a * int'($signed(w[3:0])) + hi_a * int'($signed(w[7:4]));
  endfunction

  // MAC model: input reg, mult reg (mode applied unregistered), z reg.
  logic [15:0] mr_a;
  logic [7:0]  mr_w;
  logic        mr_rst, mp_rst;
  int          mp_prod, mz;
  logic [ZW-1:0] mz_bits;
  always @(posedge clk) begin
    if (!rst_n) begin
      mr_a <= '0; mr_w <= '0; mr_rst <= 1'b0; mp_rst <= 1'b0; mp_prod <= 0; mz <= 0;
    end else begin
      mr_a    <= mac_a;
      mr_w    <= mac_w;
      mr_rst  <= mac_accu_rst;
      mp_prod <= dot(mr_a, mr_w, mac_mode);
      mp_rst  <= mr_rst;
      mz      <= mp_rst ? mp_prod : mz + mp_prod;
    end
  end
  assign mz_bits = mz[ZW-1:0];
  // In split mode the MAC leaves its upper bits stale; model that with junk.
  assign mac_z = mac_mode ? {3'b101, mz_bits[LW-1:0]} : mz_bits;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard state
  int exp_q[$];
  int last_out = 0;
  int n_out = 0;
  int mr_mode = 1;   // 0: hold m_ready low, 1: high, 2: random

  task automatic monitor();
    logic [ZW-1:0] hold_d;
    bit hold;
    int e;
    hold = 0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          chk("hold_valid", m_valid, 1);
          chk("hold_data", m_data, hold_d);
        end
        hold   = m_valid && !m_ready;
        hold_d = m_data;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got %0d expected none", $signed(m_data));
          end else begin
            e = exp_q.pop_front();
            chk("result", $signed(m_data), e);
            last_out = int'($signed(m_data));
            n_out++;
          end
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      m_ready = (mr_mode == 2) ? 1'($urandom_range(0, 1)) : (mr_mode == 1);
    end
  endtask

  // Reference model state for the window being issued.
  bit in_win = 0;
  int acc = 0;
  bit win_mode = 0;
  int wait_cyc = 0;

  task automatic beat(input logic [15:0] a, input logic [7:0] w, input logic last);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    s_valid = 1'b1; s_a = a; s_w = w; s_last = last;
    while (!ok && t < 300) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      else t++;
    end
    wait_cyc = t;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no accept expected accept within 300 cycles");
    end else begin
      chk("accu_rst", mac_accu_rst, !in_win);
      chk("mac_a", mac_a, a);
      chk("mac_w", mac_w, w);
      if (!in_win) begin
        acc = 0;
        win_mode = cfg_mode;
      end
      acc += dot(a, w, win_mode);
      in_win = !last;
      if (last) exp_q.push_back(acc);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_done", (exp_q.size() == 0) && !busy, 1);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ta [3] = '{16'd10, 16'd20, 16'd255};
  logic [7:0]  tw [3] = '{8'd3, 8'hFE, 8'd127};
  int n0;
  int len;

  initial begin
    fork
      monitor();
      ready_drv();
      begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_mode", mac_mode, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", s_ready, 1);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // 1: mode0 three-beat window
    cfg_mode = 1'b0;
    for (int i = 0; i < 3; i++) beat(ta[i], tw[i], i == 2);
    drain();
    chk("t1_value", last_out, 32375);

    // 2: mode1 two-beat window
    cfg_mode = 1'b1;
    beat(16'h0507, 8'h32, 1'b0);
    beat(16'h0507, 8'hF8, 1'b1);
    drain();
    chk("t2_value", last_out, -32);

    // 3: stalls between beats feed zeros
    cfg_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat(ta[i], tw[i], i == 2);
      if (i < 2) begin
        for (int k = 0; k < 2; k++) begin
          s_a = 16'($urandom) | 16'h0001;
          s_w = 8'($urandom) | 8'h01;
          @(negedge clk);
          chk("stall_mac_a", mac_a, 0);
          chk("stall_mac_w", mac_w, 0);
          @(posedge clk); #1;
        end
      end
    end
    drain();
    chk("t3_value", last_out, 32375);

    // 4: back-to-back single-beat windows
    beat(16'd2, 8'd3, 1'b1);
    beat(16'd4, 8'd5, 1'b1);
    chk("one_bubble", wait_cyc, 1);
    drain();
    chk("t4_value", last_out, 20);

    // 5: result backpressure exhausts credits
    mr_mode = 0;
    @(posedge clk); #1;
    n0 = n_out;
    beat(16'd1, 8'd1, 1'b1);
    beat(16'd2, 8'd1, 1'b1);
    s_valid = 1'b1; s_a = 16'd3; s_w = 8'd1; s_last = 1'b1;
    repeat (8) @(negedge clk);
    chk("credit_block", s_ready, 0);
    chk("credit_m_valid", m_valid, 1);
    mr_mode = 1;
    beat(16'd3, 8'd1, 1'b1);
    chk("pop_unblock", wait_cyc > 0, 1);
    drain();
    chk("t5_count", n_out - n0, 3);
    chk("t5_value", last_out, 3);

    // 6: mode change right after a last beat waits for capture
    cfg_mode = 1'b0;
    beat(16'd7, 8'd2, 1'b1);
    cfg_mode = 1'b1;
    beat(16'h0101, 8'h11, 1'b1);
    chk("mode_wait", wait_cyc, 3);
    chk("mode_applied", mac_mode, 1);
    drain();
    chk("t6_value", last_out, 2);

    // 7: reset mid-window discards it
    cfg_mode = 1'b0;
    beat(16'd5, 8'd5, 1'b0);
    beat(16'd6, 8'd6, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    in_win = 0;
    n0 = n_out;
    beat(16'd1, 8'd1, 1'b1);
    drain();
    chk("t7_count", n_out - n0, 1);
    chk("t7_value", last_out, 1);

    // Randomized windows with random backpressure and mode switches
    mr_mode = 2;
    for (int n = 0; n < 30; n++) begin
      cfg_mode = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        beat(16'($urandom), 8'($urandom), j == len - 1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    mr_mode = 1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
